pmem_burst_responder: RTL and testbench
=======================================

Name: pmem_burst_responder

Overview:
- Synthesizable physical-memory responder: the memory end of the `mp3` pmem burst interface.
- Answers `mem_read`/`mem_write` from the cacheline adaptor with 4-beat × 64-bit bursts after a programmable latency.
- Backed by an internal line array, which a backdoor port preloads.
- Replaces the behavioural burst memory in tb top so a full pmem round-trip can be simulated and synthesized.

Parameters:
- `LATENCY`, 10, cycles between request acceptance and first response beat (0 legal).
- `INDEX_BITS`, 8, log2 of lines stored; the array holds 2^`INDEX_BITS` 256-bit lines.
- `ADDR_WIDTH`, 32, byte-address width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `mem_read`  in  1  read request, held until final beat.
- `mem_write`  in  1  write request, held until final beat.
- `mem_addr`  in  `ADDR_WIDTH`  byte address; bits [4:0] ignored.
- `mem_wdata`  in  64  write beat.
- `mem_resp`  out  1  beat valid/accepted.
- `mem_rdata`  out  64  read beat.
- `init_we`  in  1  backdoor line write.
- `init_index`  in  `INDEX_BITS`  backdoor line index.
- `init_line`  in  256  backdoor line data.
- `protocol_err`  out  1  sticky protocol-violation flag.

Behaviour:
- Reset, sampled on edge with `rst`=0:
  - state IDLE, counters 0.
  - `mem_resp`=0, `mem_rdata`=0, `protocol_err`=0.
  - Array contents preserved.
  - Reset mid-burst aborts; `mem_resp` is low the cycle after the reset edge.
- Index = `mem_addr`[`INDEX_BITS`+4:5], with upper bits aliased. Index and direction are latched at accept; later address changes are ignored.
- FSM IDLE → WAIT → BURST → DONE → IDLE.
- IDLE:
  - Request seen at edge E0 with exactly one of `mem_read`/`mem_write` high → accept.
  - On a read accept, the line is copied to the line buffer.
  - Next state is WAIT with count `LATENCY`, or BURST if `LATENCY`=0.
  - Both requests high → `protocol_err`=1, no accept, stay IDLE.
- WAIT:
  - Count decrements each edge; at 0, go to BURST.
  - First beat is visible in the cycle after edge E0+`LATENCY`.
- BURST (beats 0..3, one per cycle, no stalls):
  - `mem_resp`=1 in every BURST cycle.
  - Read: `mem_rdata` = line_buffer[64k+63:64k] for beat k.
  - Write: `mem_wdata` is written to array line[64k+63:64k] at the edge ending beat k.
  - The requester must present beat k while beat counter = k.
  - After beat 3, go to DONE.
- DONE: one cycle, `mem_resp`=0, requests ignored, then IDLE. The next accept is possible at the earliest at edge E0+`LATENCY`+5.
- Request dropped during WAIT or BURST:
  - `protocol_err`=1, return to IDLE next edge.
  - Write beats already committed remain.
- `mem_rdata` holds its last value outside read BURST cycles. Beat values change only on edges.
- Backdoor:
  - `init_we` in IDLE with no simultaneous accept: whole line written at edge.
  - `init_we` in any other state: ignored, `protocol_err`=1.
  - `init_we` while a request is being accepted: ignored, `protocol_err`=1; the request is still accepted.
  - A read returns the line-buffer snapshot, so it is unaffected by any array change after accept.
- `protocol_err` clears only on reset.

Decomposition:
- Package `pmem_resp_pkg`:
  - state enum (IDLE, WAIT, BURST, DONE).
  - `LINE_BITS`=256, `BEAT_BITS`=64, `BURST_LEN`=4, `OFFSET_BITS`=5.
  - `line_t`, `beat_idx_t` (2-bit).
- Sub-module `pmem_line_store`: 2^`INDEX_BITS` × 256 array with:
  - one 256-bit backdoor write port;
  - one 64-bit beat write port (index, beat, data);
  - one combinational 256-bit read port.
- FSM, counters and line buffer stay in the top module.

Test Plan:
- Preload index 3 with line 0x…_4444_4444_4444_4444_3333…_2222…_1111_1111_1111_1111 (beats 3..0 as shown); `mem_read`, `mem_addr`=0x60, `LATENCY`=10 → `mem_resp` high for 4 cycles starting 11 cycles after accept edge, beats 0x1111…, 0x2222…, 0x3333…, 0x4444…; then 1 low DONE cycle.
- `mem_write` `mem_addr`=0x80 with beats 0xA0..0xA3, then read 0x80 → identical 4 beats returned, `protocol_err`=0.
- `LATENCY`=0 read → `mem_resp` high in the cycle immediately after accept edge; back-to-back read accepted exactly 5 edges after the first accept.
- `mem_read`=`mem_write`=1 → no `mem_resp` ever, `protocol_err`=1 until `rst`=0.
- Drop `mem_write` after beat 1 → `protocol_err`=1, IDLE next cycle, a subsequent read shows beats 0–1 new and beats 2–3 old.
- Assert `rst`=0 during read beat 2 → `mem_resp`=0 the following cycle, array unchanged; new read after release returns full line.

Source files
------------

// File: rtl/pmem_resp_pkg.sv
// Shared types and constants for the pmem burst responder and its line store.
// A line is four 64-bit beats; beat k occupies bits [64k+63:64k].
package pmem_resp_pkg;

    localparam int LINE_BITS   = 256;
    localparam int BEAT_BITS   = 64;
    localparam int BURST_LEN   = 4;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_e;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [1:0]           beat_idx_t;

    function automatic beat_t line_beat(input line_t line, input beat_idx_t k);
        return line[{k, 6'd0} +: BEAT_BITS];
    endfunction

endpackage

// File: rtl/pmem_line_store.sv
// Line array behind the responder: whole-line backdoor write, per-beat write,
// and a combinational full-line read. Contents are never reset.
module pmem_line_store
    import pmem_resp_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  init_we_i,
    input  logic [INDEX_BITS-1:0] init_index_i,
    input  logic [LINE_BITS-1:0]  init_line_i,
    input  logic                  beat_we_i,
    input  logic [INDEX_BITS-1:0] beat_index_i,
    input  logic [1:0]            beat_idx_i,
    input  logic [BEAT_BITS-1:0]  beat_data_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic [LINE_BITS-1:0]  rd_line_o
);

    line_t mem_q [2**INDEX_BITS];

    // The two write ports are never active together; the backdoor wins anyway.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            mem_q[init_index_i] <= init_line_i;
        end else if (beat_we_i) begin
            mem_q[beat_index_i][{beat_idx_i, 6'd0} +: BEAT_BITS] <= beat_data_i;
        end
    end

    assign rd_line_o = mem_q[rd_index_i];

endmodule

// File: rtl/pmem_burst_responder.sv
// Memory end of the pmem burst interface: accepts a line read/write, waits
// LATENCY cycles, then streams four 64-bit beats.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; backdoor line writes allowed
// ST_WAIT  | request accepted, latency counter running down to zero
// ST_BURST | one beat per cycle, mem_resp high, beat_q selects the beat
// ST_DONE  | single quiet cycle; a request present at its exit edge is taken
module pmem_burst_responder
    import pmem_resp_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [BEAT_BITS-1:0]  mem_wdata_i,
    output logic                  mem_resp_o,
    output logic [BEAT_BITS-1:0]  mem_rdata_o,
    input  logic                  init_we_i,
    input  logic [INDEX_BITS-1:0] init_index_i,
    input  logic [LINE_BITS-1:0]  init_line_i,
    output logic                  protocol_err_o
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    beat_idx_t               beat_q;
    beat_idx_t               beat_d;
    logic [INDEX_BITS-1:0]   idx_q;
    logic                    is_write_q;
    line_t                   line_buf_q;
    logic                    resp_q;
    beat_t                   rdata_q;
    logic                    err_q;

    logic [INDEX_BITS-1:0]   req_idx;
    line_t                   rd_line;
    logic                    one_req;
    logic                    both_req;
    logic                    can_accept;
    logic                    accept;
    logic                    dir_held;
    logic                    init_ok;
    logic                    store_init_we;
    logic                    store_beat_we;
    logic                    unused_addr_bits;

    assign req_idx          = mem_addr_i[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign unused_addr_bits = ^{mem_addr_i[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS],
                                mem_addr_i[OFFSET_BITS-1:0]};

    assign one_req    = mem_read_i ^ mem_write_i;
    assign both_req   = mem_read_i & mem_write_i;
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept     = can_accept && one_req;
    assign dir_held   = is_write_q ? mem_write_i : mem_read_i;
    assign init_ok    = (state_q == ST_IDLE) && !accept;
    assign beat_d     = beat_q + 2'd1;

    // A dropped write request commits nothing at the edge that sees the drop.
    assign store_init_we = rst_i && init_we_i && init_ok;
    assign store_beat_we = rst_i && (state_q == ST_BURST) && is_write_q && mem_write_i;

    pmem_line_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk_i        (clk_i),
        .init_we_i    (store_init_we),
        .init_index_i (init_index_i),
        .init_line_i  (init_line_i),
        .beat_we_i    (store_beat_we),
        .beat_index_i (idx_q),
        .beat_idx_i   (beat_q),
        .beat_data_i  (mem_wdata_i),
        .rd_index_i   (req_idx),
        .rd_line_o    (rd_line)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            idx_q      <= '0;
            is_write_q <= 1'b0;
            line_buf_q <= '0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (both_req && can_accept) begin
                err_q <= 1'b1;
            end
            if (init_we_i && !init_ok) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    resp_q <= 1'b0;
                    if (accept) begin
                        idx_q      <= req_idx;
                        is_write_q <= mem_write_i;
                        beat_q     <= '0;
                        cnt_q      <= LAT_LOAD;
                        if (mem_read_i) begin
                            line_buf_q <= rd_line;
                        end
                        if (LATENCY == 0) begin
                            state_q <= ST_BURST;
                            resp_q  <= 1'b1;
                            if (mem_read_i) begin
                                rdata_q <= line_beat(rd_line, 2'd0);
                            end
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!dir_held) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_BURST;
                        resp_q  <= 1'b1;
                        if (!is_write_q) begin
                            rdata_q <= line_beat(line_buf_q, 2'd0);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (!dir_held) begin
                        err_q   <= 1'b1;
                        resp_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (beat_q == 2'd3) begin
                        resp_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        beat_q <= beat_d;
                        if (!is_write_q) begin
                            rdata_q <= line_beat(line_buf_q, beat_d);
                        end
                    end
                end
                default: begin
                    resp_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_resp_o     = resp_q;
    assign mem_rdata_o    = rdata_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench: one responder with LATENCY=10 and one with LATENCY=0,
// sharing clock, reset, address, write data and backdoor.
module tb_pmem_burst_responder;

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [63:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd10 = 1'b0, wr10 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic         init_we = 1'b0;
    logic [7:0]   init_idx = '0;
    logic [255:0] init_line = '0;
    logic         resp10, resp0, err10, err0;
    logic [63:0]  rdata10, rdata0;

    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         q10[$];
    exp_t         q0[$];

    localparam logic [255:0] L3 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L5 = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                                   64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    localparam logic [255:0] L6 = {64'h6666_0000_0000_0D03, 64'h6666_0000_0000_0D02,
                                   64'h6666_0000_0000_0D01, 64'h6666_0000_0000_0D00};
    localparam logic [255:0] WA = {64'h0000_0000_0000_00A3, 64'h0000_0000_0000_00A2,
                                   64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00A0};
    localparam logic [255:0] WB = {64'h0, 64'h0,
                                   64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00B0};
    localparam logic [255:0] L5_MIX = {L5[255:128], WB[127:0]};

    pmem_burst_responder #(.LATENCY(10), .INDEX_BITS(8), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .mem_read_i(rd10), .mem_write_i(wr10),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_resp_o(resp10), .mem_rdata_o(rdata10),
        .init_we_i(init_we), .init_index_i(init_idx), .init_line_i(init_line),
        .protocol_err_o(err10)
    );

    pmem_burst_responder #(.LATENCY(0), .INDEX_BITS(8), .ADDR_WIDTH(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .mem_read_i(rd0), .mem_write_i(wr0),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_resp_o(resp0), .mem_rdata_o(rdata0),
        .init_we_i(init_we), .init_index_i(init_idx), .init_line_i(init_line),
        .protocol_err_o(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic mon_beat(input bit d0, input logic [63:0] got);
        exp_t e;
        checks++;
        if ((d0 ? q0.size() : q10.size()) == 0) begin
            errors++;
            $display("FAIL %s unexpected mem_resp: rdata %h at cycle %0d, expected none",
                     d0 ? "lat0" : "lat10", got, cyc);
        end else begin
            e = d0 ? q0.pop_front() : q10.pop_front();
            if (e.cyc != cyc || (e.chk && got !== e.data)) begin
                errors++;
                $display("FAIL %s beat: got rdata %h at cycle %0d, expected %h at cycle %0d",
                         d0 ? "lat0" : "lat10", got, cyc, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resp10 === 1'b1) mon_beat(1'b0, rdata10);
        if (resp0 === 1'b1) mon_beat(1'b1, rdata0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        check({name, " pending beats"}, 64'(q10.size() + q0.size()), 64'd0);
        q10.delete();
        q0.delete();
    endtask

    task automatic push(input bit d0, input int unsigned c, input bit chk, input logic [63:0] d);
        exp_t e;
        e.cyc = c; e.chk = chk; e.data = d;
        if (d0) q0.push_back(e); else q10.push_back(e);
    endtask

    task automatic set_req(input bit d0, input bit wr, input bit on);
        if (d0) begin rd0 = on & !wr; wr0 = on & wr; end
        else begin rd10 = on & !wr; wr10 = on & wr; end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [255:0] line);
        init_idx = idx; init_line = line; init_we = 1'b1;
        tick(1);
        init_we = 1'b0;
    endtask

    // Full burst held until the edge ending beat 3, then released.
    task automatic burst(input bit d0, input bit wr, input logic [31:0] a,
                         input logic [255:0] wline, input logic [255:0] rline);
        int unsigned lat;
        int unsigned e0;
        lat = d0 ? 0 : 10;
        addr = a;
        wdata = wline[63:0];
        set_req(d0, wr, 1'b1);
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) push(d0, e0 + lat + k, !wr, rline[64*k +: 64]);
        tick(1 + lat);
        for (int k = 1; k < 4; k++) begin
            tick(1);
            wdata = wline[64*k +: 64];
        end
        tick(1);
        set_req(d0, wr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        tick(2);
        check("reset resp10", 64'(resp10), 64'd0);
        check("reset rdata10", rdata10, 64'd0);
        check("reset err10", 64'(err10), 64'd0);
        check("reset resp0", 64'(resp0), 64'd0);
        rst = 1'b1;
        tick(1);
        preload(8'd3, L3);
        preload(8'd5, L5);
        preload(8'd6, L6);

        // zero latency, back-to-back reads five edges apart
        burst(1'b1, 1'b0, 32'h60, '0, L3);
        burst(1'b1, 1'b0, 32'hC0, '0, L6);
        tick(2);
        drain("lat0 b2b");

        // basic read with latency 10, then DONE quiet cycle and held rdata
        burst(1'b0, 1'b0, 32'h60, '0, L3);
        check("rdata hold", rdata10, 64'h4444_4444_4444_4444);
        tick(2);
        drain("read idx3");

        // write then read back, upper address bits aliased
        burst(1'b0, 1'b1, 32'h80, WA, '0);
        tick(1);
        burst(1'b0, 1'b0, 32'hF000_0080, '0, WA);
        tick(2);
        drain("write/read idx4");
        check("err after clean traffic", 64'(err10), 64'd0);

        // reset during read beat 2
        addr = 32'h60;
        rd10 = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) push(1'b0, e0 + 10 + k, 1'b1, L3[64*k +: 64]);
        tick(11);
        tick(2);
        rst = 1'b0;
        rd10 = 1'b0;
        tick(1);
        check("resp after reset edge", 64'(resp10), 64'd0);
        check("rdata after reset edge", rdata10, 64'd0);
        tick(1);
        rst = 1'b1;
        tick(2);
        burst(1'b0, 1'b0, 32'h60, '0, L3);
        tick(2);
        drain("reset mid-burst");

        // both requests high: never accepted, sticky error
        addr = 32'h60;
        rd10 = 1'b1;
        wr10 = 1'b1;
        tick(3);
        check("err both-high", 64'(err10), 64'd1);
        rd10 = 1'b0;
        wr10 = 1'b0;
        tick(15);
        check("err sticky", 64'(err10), 64'd1);
        drain("both-high");
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("err cleared by reset", 64'(err10), 64'd0);
        tick(1);

        // write dropped after beat 1
        addr = 32'hA0;
        wdata = WB[63:0];
        wr10 = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) push(1'b0, e0 + 10 + k, 1'b0, '0);
        tick(11);
        tick(1);
        wdata = WB[127:64];
        tick(1);
        wr10 = 1'b0;
        tick(1);
        check("resp after drop", 64'(resp10), 64'd0);
        check("err after drop", 64'(err10), 64'd1);
        burst(1'b0, 1'b0, 32'hA0, '0, L5_MIX);
        tick(2);
        drain("drop write");
        check("lat0 err", 64'(err0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
